hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
- Parametrised successor to the HI/LO register pair.
- Holds HI/LO and adds an iterative multiply/divide engine that writes its 2W-bit result into HI/LO. MTHI/MTLO writes also land here.
- Sits beside the EX stage: the pipeline issues an op, stalls on busy, and reads HI/LO through a masked read port.
- Supports flush, used on exception or branch squash.

Parameters:
- W, 32: operand, HI and LO width. Must be even and ≥ 8.
- CNT_W, $clog2(W)+1: width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  op request.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- src_a  in  W  multiplicand / dividend / MTHI-MTLO data.
- src_b  in  W  multiplier / divisor.
- op_ready  out  1  high when idle; the op is accepted on an edge with op_valid & op_ready & !flush.
- flush  in  1  cancel any in-flight op and block acceptance this cycle.
- busy  out  1  engine is in a non-IDLE state.
- done  out  1  one-cycle pulse during the write (FIX) cycle of MULT/DIV class ops.
- ren  in  2  read enable: bit1 selects HI, bit0 selects LO.
- rdata  out  W  ({W{ren[0]}} & lo) | ({W{ren[1]}} & hi), combinational.
- hi  out  W  current HI.
- lo  out  W  current LO.

Behaviour:
- Reset (async, high): hi = lo = 0, state = IDLE, so busy = 0, done = 0, op_ready = 1. The counter and working registers are cleared. Reset mid-operation aborts the op with no HI/LO write.
- States:
  - IDLE: on accept of MULT/MULTU/MADD/MSUB go to MUL; DIV/DIVU go to DIV; MTHI/MTLO write at the accept edge and stay in IDLE.
  - MUL, DIV: W iteration cycles, counted down from W.
  - FIX: one cycle; done = 1; HI/LO written at the edge leaving FIX; next state IDLE.
- Latency: HI/LO are updated on the (W+1)th rising edge after the accept edge. The new value is visible on rdata the cycle after. busy is high for exactly W+1 cycles.
- Operands are latched at accept; src_a/src_b may change afterwards.
- MUL:
  - Shift-add on operand magnitudes, one bit per cycle, into a 2W-bit product.
  - Signed ops (MULT/MADD/MSUB) negate the product in FIX iff the operand signs differ.
  - {hi, lo} = product.
- DIV:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Signed: quotient negative iff the signs differ; remainder takes the dividend's sign.
  - lo = quotient, hi = remainder.
  - Signed overflow (-2^(W-1) / -1): lo = -2^(W-1), hi = 0.
  - Divide by zero, signed or unsigned: full latency, then lo = all-ones, hi = src_a.
- MTHI/MTLO: accepted only when op_ready. hi (or lo) = src_a at the accept edge. No done pulse.
- flush:
  - In MUL/DIV/FIX: next state IDLE, no HI/LO write, done forced 0 that cycle.
  - In IDLE: the op is not accepted, including MTHI/MTLO.
- op_valid while busy is ignored. The requester must hold it until accepted.
- Read during the FIX cycle returns the old HI/LO, with no bypass.

Optional Feature:
- Macro HILO_MADD_EN.
- Defined: MADD gives {hi, lo} = {hi, lo} + signed product; MSUB gives {hi, lo} = {hi, lo} − signed product. Arithmetic is modulo 2^(2W) and is performed in FIX using the HI/LO values at FIX time.
- Undefined: op 110/111 are accepted, take no cycles, leave HI/LO unchanged, and do not pulse done.

Test Plan:
- W=32: MULT a=0xFFFFFFFE, b=3 → busy 33 cycles, done pulse in cycle 33, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. MTHI 0x1234 in the next idle cycle → hi=0x1234 one edge later, with ren=2'b10 giving rdata=0x1234.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=100, b=0 → after 33 cycles lo=0xFFFFFFFF, hi=100.
- Flush and reset:
  - Start DIVU 100/7, flush in iteration cycle 10 → op_ready=1 next cycle, no done, hi/lo unchanged.
  - Repeat with reset asserted mid-op → hi=lo=0 immediately.
- HILO_MADD_EN defined: hi=0, lo=1, MADD 2×3 → lo=7. Then MSUB 4×2 → {hi, lo}=0xFFFFFFFF_FFFFFFFF. Undefined: the same sequence leaves lo=1.

Source files
------------

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with an iterative shift-add multiplier / restoring divider.
// Optional MADD/MSUB accumulation into HI/LO is enabled by defining HILO_MADD_EN.
module hilo_muldiv #(
  parameter int unsigned W = 32,
  localparam int unsigned CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         op_valid,
  input  logic [2:0]   op,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  output logic         op_ready,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  input  logic [1:0]   ren,
  output logic [W-1:0] rdata,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;
`ifdef HILO_MADD_EN
  localparam logic [2:0] OpMadd  = 3'b110;
  localparam logic [2:0] OpMsub  = 3'b111;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic [W-1:0]     a_q, a_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;

  logic           accept;
  logic           is_signed;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     mul_sum;
  logic [W:0]     div_trial;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo, rem, div_lo, div_hi;

  assign op_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFix) && !flush;
  assign accept   = op_valid && op_ready && !flush;

  assign is_signed = !(op == OpMultu || op == OpDivu);
  assign mag_a     = (is_signed && src_a[W-1]) ? -src_a : src_a;
  assign mag_b     = (is_signed && src_b[W-1]) ? -src_b : src_b;

  // acc holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
  assign div_trial = acc_q[2*W-1:W-1] - {1'b0, opnd_q};

  assign prod_s = neg_q ? -acc_q : acc_q;
  assign quo    = acc_q[W-1:0];
  assign rem    = acc_q[2*W-1:W];
  assign div_lo = dz_q ? {W{1'b1}} : (neg_q ? -quo : quo);
  assign div_hi = dz_q ? a_q : (rneg_q ? -rem : rem);

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = ({W{ren[0]}} & lo_q) | ({W{ren[1]}} & hi_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    a_d     = a_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d   = op;
          a_d    = src_a;
          cnt_d  = CNT_W'(W);
          neg_d  = is_signed && (src_a[W-1] ^ src_b[W-1]);
          rneg_d = is_signed && src_a[W-1];
          dz_d   = (src_b == '0);
          case (op)
`ifdef HILO_MADD_EN
            OpMult, OpMultu, OpMadd, OpMsub: begin
`else
            OpMult, OpMultu: begin
`endif
              state_d = StMul;
              opnd_d  = mag_a;
              acc_d   = {{W{1'b0}}, mag_b};
            end
            OpDiv, OpDivu: begin
              state_d = StDiv;
              opnd_d  = mag_b;
              acc_d   = {{W{1'b0}}, mag_a};
            end
            OpMthi:  hi_d = src_a;
            OpMtlo:  lo_d = src_a;
            default: ;
          endcase
        end
      end
      StMul: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = StFix;
        end
      end
      StDiv: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          if (!div_trial[W]) acc_d = {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
          else               acc_d = {acc_q[2*W-2:0], 1'b0};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          case (op_q)
            OpDiv, OpDivu: begin
              hi_d = div_hi;
              lo_d = div_lo;
            end
`ifdef HILO_MADD_EN
            OpMadd:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OpMsub:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
`endif
            default: {hi_d, lo_d} = prod_s;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      a_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      a_q     <= a_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv (W=32); honours HILO_MADD_EN.
module tb_hilo_muldiv;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         op_valid = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         flush = 1'b0;
  logic [1:0]   ren = 2'b11;
  logic         op_ready, busy, done;
  logic [W-1:0] rdata, hi, lo;

  int checks = 0;
  int failures = 0;
  int nbusy, ndone;
  logic [W-1:0] rd_fix;
  logic dseen;

  hilo_muldiv #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .op_ready (op_ready),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .ren      (ren),
    .rdata    (rdata),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the sources after accept, and count busy cycles.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op = o; src_a = a; src_b = b; op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0; src_a = 32'h5A5A_A5A5; src_b = 32'h0F0F_1234;
    nbusy = 0; ndone = 0; rd_fix = '0;
    while (busy && nbusy < 100) begin
      nbusy++;
      if (done) begin
        ndone = nbusy;
        rd_fix = rdata;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", op_ready, 1);
    reset = 1'b0;

    run_op(3'b000, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy", nbusy, 33);
    check("mult_done_cyc", ndone, 33);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    ren = 2'b01; #1;
    check("rd_lo", rdata, 32'hFFFF_FFFA);
    ren = 2'b00; #1;
    check("rd_none", rdata, 0);
    ren = 2'b11;

    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(3'b100, 32'h1234, 32'h0);
    check("mthi_busy", nbusy, 0);
    check("mthi_hilo", {hi, lo}, 64'h0000_1234_0000_0001);
    ren = 2'b10; #1;
    check("mthi_rd", rdata, 32'h1234);

    run_op(3'b010, 32'hFFFF_FFF9, 32'd2);
    check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

    run_op(3'b011, 32'd100, 32'd0);
    check("divz_busy", nbusy, 33);
    check("divz_hilo", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    check("divz_rd_fix_old", rd_fix, 0);
    ren = 2'b11;

    // Flush in iteration cycle 10 of DIVU 100/7
    @(negedge clk);
    op = 3'b011; src_a = 32'd100; src_b = 32'd7; op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    dseen = 1'b0;
    repeat (9) begin
      if (done) dseen = 1'b1;
      @(negedge clk);
    end
    check("pre_flush_busy", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", op_ready, 1);
    repeat (40) begin
      if (done) dseen = 1'b1;
      @(negedge clk);
    end
    check("flush_nodone", dseen, 0);
    check("flush_hilo", {hi, lo}, 64'h0000_0064_FFFF_FFFF);

    // Flush in IDLE blocks MTLO
    @(negedge clk);
    op = 3'b101; src_a = 32'hDEAD; op_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    check("flush_idle_lo", lo, 32'hFFFF_FFFF);

    // Reset mid-op
    @(negedge clk);
    op = 3'b011; src_a = 32'd100; src_b = 32'd7; op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_hilo", {hi, lo}, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op(3'b100, 32'h0, 32'h0);
    run_op(3'b101, 32'h1, 32'h0);
    run_op(3'b110, 32'd2, 32'd3);
`ifdef HILO_MADD_EN
    check("madd_done_cyc", ndone, 33);
    check("madd_hilo", {hi, lo}, 64'h0000_0000_0000_0007);
`else
    check("madd_busy", nbusy, 0);
    check("madd_hilo", {hi, lo}, 64'h0000_0000_0000_0001);
`endif
    run_op(3'b111, 32'd4, 32'd2);
`ifdef HILO_MADD_EN
    check("msub_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    check("msub_done_cyc", ndone, 0);
    check("msub_hilo", {hi, lo}, 64'h0000_0000_0000_0001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
